// File: rtl/instruction_encoder_pkg.sv
// Shared RV32I encoder types: instruction formats, opcodes, the canonical NOP
// and the immediate sign-extension test used by the optional range check.
package instr_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } instr_fmt_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // True when imm[31:lsb] are all copies of imm[31], i.e. the value survives
  // truncation to an (lsb+1)-bit signed field.
  function automatic logic imm_fits(input logic [31:0] imm, input int lsb);
    logic fits;
    fits = 1'b1;
    for (int i = 0; i < 31; i++) begin
      if (i >= lsb && imm[i] != imm[31]) begin
        fits = 1'b0;
      end
    end
    return fits;
  endfunction

endpackage

// File: rtl/instruction_field_packer.sv
// Combinational RV32I format mux; with IMM_RANGE_CHECK_EN defined it also flags
// immediates that do not fit their field or illegal formats.
module instruction_field_packer
  import instr_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word
`ifdef IMM_RANGE_CHECK_EN
  ,
  output logic        err
`endif
);

  always_comb begin
    word = NOP_WORD;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = NOP_WORD;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Branch and jump offsets are halfword aligned, so a set bit 0 is an error.
  always_comb begin
    err = 1'b0;
    case (fmt)
      FMT_R:        err = 1'b0;
      FMT_I, FMT_S: err = !imm_fits(imm, 11);
      FMT_B:        err = !imm_fits(imm, 12) || imm[0];
      FMT_J:        err = !imm_fits(imm, 20) || imm[0];
      FMT_U:        err = |imm[11:0];
      default:      err = 1'b1;
    endcase
  end
`else
  logic unused_imm_lsb;
  assign unused_imm_lsb = imm[0];
`endif

endmodule

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: packs fields, tags each word with a sequential
// byte address and buffers it in a small FIFO. Optional macro: IMM_RANGE_CHECK_EN.
module instruction_encoder
  import instr_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  logic [31:0]       enc_word;
  logic [31:0]       word_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [ADDR_W-1:0] addr_cnt;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  rd_idx;

`ifdef IMM_RANGE_CHECK_EN
  logic              enc_err;
  logic [DEPTH-1:0]  err_mem;
`endif

  instruction_field_packer u_packer (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .word   (enc_word)
`ifdef IMM_RANGE_CHECK_EN
    ,
    .err    (enc_err)
`endif
  );

  assign wr_idx    = wr_ptr[PTR_W-1:0];
  assign rd_idx    = rd_ptr[PTR_W-1:0];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      addr_cnt <= BASE;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      addr_cnt <= BASE;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        addr_cnt <= addr_cnt + STEP;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_idx] <= enc_word;
      addr_mem[wr_idx] <= addr_cnt;
`ifdef IMM_RANGE_CHECK_EN
      err_mem[wr_idx]  <= enc_err;
`endif
    end
  end

  // Outputs read as zero whenever the FIFO is empty, including straight out of reset.
  assign out_word = out_valid ? word_mem[rd_idx] : '0;
  assign out_addr = out_valid ? addr_mem[rd_idx] : '0;
`ifdef IMM_RANGE_CHECK_EN
  assign out_err  = out_valid && err_mem[rd_idx];
`else
  assign out_err  = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: directed encodings, full/flush/reset
// behaviour and a second instance with ADDR_W=4 for address wrap.
module tb_instruction_encoder;
  import instr_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] word;
    logic [11:0] addr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [11:0] out_addr;
  logic        out_err;

  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] out_word4;
  logic [3:0]  out_addr4;
  logic        out_err4;

  exp_t        q[$];
  logic [11:0] exp_addr;
  logic [31:0] cur_word;
  logic        cur_err;
  bit          running = 0;
  int          checks_n = 0;
  int          errors_n = 0;

  always #5 clk = ~clk;

  instruction_encoder #(.DEPTH(4), .ADDR_W(12), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .out_err(out_err)
  );

  instruction_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_word(out_word4), .out_addr(out_addr4), .out_err(out_err4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_n++;
    if (actual !== expected) begin
      errors_n++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
    end
  endtask

  // The range-check flag is only meaningful when the optional check is built in.
  function automatic logic expErr(input logic e);
`ifdef IMM_RANGE_CHECK_EN
    return e;
`else
    return 1'b0 & e;
`endif
  endfunction

  task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm,
                               input logic [31:0] word, input logic err);
    bit accepted = 0;
    in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    cur_word = word;
    cur_err  = expErr(err);
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) checkOutput("drain_timeout", q.size(), 32'd0);
  endtask

  // Scoreboard: handshakes are sampled mid-cycle, ahead of the edge that performs them.
  always @(negedge clk) begin
    if (running) begin
      if (!rst_n) begin
        q.delete();
        exp_addr = 12'h000;
      end else begin
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, q.size() < DEPTH});
        if (flush) begin
          q.delete();
          exp_addr = 12'h000;
        end else begin
          if (out_valid && out_ready && q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checkOutput("out_word", out_word, e.word);
            checkOutput("out_addr", {20'd0, out_addr}, {20'd0, e.addr});
            checkOutput("out_err", {31'd0, out_err}, {31'd0, e.err});
            checkOutput("addr_w4", {28'd0, out_addr4}, {28'd0, e.addr[3:0]});
            checkOutput("word_w4", out_word4, e.word);
          end
          if (in_valid && in_ready) begin
            q.push_back('{word: cur_word, addr: exp_addr, err: cur_err});
            exp_addr = exp_addr + 12'd4;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = 3'd0; in_opcode = 7'd0; in_funct3 = 3'd0; in_funct7 = 7'd0;
    in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
    cur_word = 32'd0; cur_err = 1'b0; exp_addr = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_word", out_word, 32'd0);
    checkOutput("rst_out_addr", {20'd0, out_addr}, 32'd0);
    checkOutput("rst_out_err", {31'd0, out_err}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    running = 1;

    // Directed encodings, streamed with the consumer always ready
    out_ready = 1'b1;
    applyStimulus(FMT_R, OP_REG,    3'd0, 7'h00, 5'd3, 5'd1, 5'd2,  32'h0000_0000, 32'h002081B3, 1'b0);
    applyStimulus(FMT_I, OP_IMM,    3'd0, 7'h00, 5'd1, 5'd0, 5'd0,  32'hFFFF_FFFF, 32'hFFF00093, 1'b0);
    applyStimulus(FMT_B, OP_BRANCH, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2,  32'hFFFF_FFFC, 32'hFE208EE3, 1'b0);
    applyStimulus(FMT_U, OP_LUI,    3'd0, 7'h00, 5'd5, 5'd0, 5'd0,  32'h1234_5000, 32'h123452B7, 1'b0);
    applyStimulus(FMT_J, OP_JAL,    3'd0, 7'h00, 5'd1, 5'd0, 5'd0,  32'h0000_0800, 32'h001000EF, 1'b0);
    applyStimulus(FMT_S, OP_STORE,  3'd2, 7'h00, 5'd0, 5'd2, 5'd5,  32'h0000_0008, 32'h00512423, 1'b0);
    applyStimulus(FMT_R, OP_REG,    3'd0, 7'h20, 5'd1, 5'd2, 5'd3,  32'h0000_0000, 32'h403100B3, 1'b0);
    applyStimulus(FMT_I, OP_IMM,    3'd0, 7'h7F, 5'd1, 5'd0, 5'd31, 32'h0000_0005, 32'h00500093, 1'b0);
    applyStimulus(3'd6,  OP_REG,    3'd7, 7'h7F, 5'd9, 5'd9, 5'd9,  32'h0000_1234, 32'h00000013, 1'b1);
    applyStimulus(3'd7,  OP_IMM,    3'd1, 7'h01, 5'd2, 5'd3, 5'd4,  32'h0000_0000, 32'h00000013, 1'b1);
    applyStimulus(FMT_I, OP_IMM,    3'd0, 7'h00, 5'd1, 5'd0, 5'd0,  32'h0000_0800, 32'h80000093, 1'b1);
    applyStimulus(FMT_B, OP_BRANCH, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0,  32'h0000_0002, 32'h00000163, 1'b0);
    applyStimulus(FMT_B, OP_BRANCH, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0,  32'h0000_0003, 32'h00000163, 1'b1);
    applyStimulus(FMT_U, OP_LUI,    3'd0, 7'h00, 5'd5, 5'd0, 5'd0,  32'h1234_5678, 32'h123452B7, 1'b1);
    drain();

    // Flush with three words buffered; the push offered alongside must vanish
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(FMT_I, OP_IMM, 3'd0, 7'h00, 5'(i + 1), 5'd0, 5'd0, 32'(i), 32'h00000093 | (32'(i + 1) << 7) | (32'(i) << 20), 1'b0);
    end
    flush = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Fill to DEPTH from BASE_ADDR, then release the consumer for the fifth word
    for (int i = 0; i < 4; i++) begin
      applyStimulus(FMT_R, OP_REG, 3'd0, 7'h00, 5'(i), 5'd1, 5'd2, 32'd0, 32'h00208033 | (32'(i) << 7), 1'b0);
    end
    @(negedge clk);
    checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("full_head_addr", {20'd0, out_addr}, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(FMT_U, OP_LUI, 3'd0, 7'h00, 5'd7, 5'd0, 5'd0, 32'hABCDE000, 32'hABCDE3B7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(FMT_J, OP_JAL, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h001000EF, 1'b0);
    end
    drain();

    // Asynchronous reset in the middle of a burst
    out_ready = 1'b0;
    applyStimulus(FMT_R, OP_REG, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
    applyStimulus(FMT_R, OP_REG, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("arst_out_word", out_word, 32'd0);
    checkOutput("arst_out_addr", {20'd0, out_addr}, 32'd0);
    checkOutput("arst_out_valid4", {31'd0, out_valid4}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(FMT_I, OP_IMM, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0);
    drain();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Builds 32-bit RV32I instruction words from decoded fields (format, opcode, funct3/funct7, register indices, full 32-bit immediate). It is the inverse of the decode path.
- Each word is tagged with a sequential instruction-memory byte address and buffered in a small FIFO.
- Drives the loader / self-test path that writes programs into instruction memory.
- valid/ready handshake on both sides.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- ADDR_W, 12, width of out_addr in bits
- BASE_ADDR, 0, first address issued after reset or flush (multiple of 4)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- flush  in  1  synchronous clear of FIFO and address counter
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept
- in_fmt  in  3  instr_fmt_t format selector
- in_opcode  in  7  opcode[6:0]
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R only)
- in_rd  in  5  rd
- in_rs1  in  5  rs1
- in_rs2  in  5  rs2
- in_imm  in  32  architectural immediate (sign-extended byte value; U: value with low 12 bits zero)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_word  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address of out_word
- out_err  out  1  immediate/format error for out_word (0 unless IMM_RANGE_CHECK_EN)

Behaviour:
- Reset (rst_n=0, async): FIFO empty, out_valid=0, out_word=0, out_addr=0, out_err=0, address counter=BASE_ADDR. in_ready=1 after reset releases.
- Encoding is combinational on the inputs. All layouts are standard RV32I with opcode at [6:0]:
  - R: funct7 at [31:25], rs2 at [24:20], rs1 at [19:15], funct3 at [14:12], rd at [11:7].
  - I: imm[11:0] at [31:20]; rs1, funct3, rd as R.
  - S: imm[11:5] at [31:25], imm[4:0] at [11:7]; rs2, rs1, funct3 as R.
  - B: imm[12] at [31], imm[10:5] at [30:25], imm[4:1] at [11:8], imm[11] at [7]; rs2, rs1, funct3 as R.
  - U: imm[31:12] at [31:12]; rd at [11:7].
  - J: imm[20] at [31], imm[10:1] at [30:21], imm[11] at [20], imm[19:12] at [19:12]; rd at [11:7].
- Unused fields are ignored (e.g. funct7 outside R, rs2 in I).
- Illegal in_fmt (6, 7): emit NOP 32'h0000_0013.
- Push on in_valid && in_ready. The word, the current address counter and the error bit are written to the FIFO tail. The counter then advances by 4 and wraps modulo 2^ADDR_W.
- in_ready = !full. There is no same-cycle pass-through when full, so in_ready is a registered-state function only.
- Pop on out_valid && out_ready. out_* show the FIFO head; they are held stable while out_valid && !out_ready.
- Latency: a push into an empty FIFO gives out_valid=1 on the next cycle.
- Simultaneous push and pop while neither full nor empty: both occur; occupancy is unchanged.
- Simultaneous push and pop when empty: only the push occurs (out_valid was 0).
- Pop when full frees a slot; in_ready rises the next cycle.
- Pointers are log2(DEPTH) bits wide plus a wrap bit for full/empty detection.
- flush=1 has priority over push and pop: FIFO empties and the counter returns to BASE_ADDR on the next edge. A push in the same cycle is discarded, and in_ready is still asserted if not full.
- Reset mid-stream discards all buffered words immediately.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN. When defined, out_err=1 for a word if any of these hold:
  - I/S: in_imm[31:11] not all equal.
  - B: in_imm[31:12] not all equal, or in_imm[0]=1.
  - J: in_imm[31:20] not all equal, or in_imm[0]=1.
  - U: in_imm[11:0] != 0.
  - Illegal fmt.
  - R never errors.
- Words are still emitted with the truncated fields.
- When not defined: no check logic and no FIFO error bit; out_err tied 0.

Decomposition:
- Package instr_pkg:
  - instr_fmt_t enum (FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5).
  - NOP_WORD constant.
  - Opcode constants: OP_LUI, OP_JAL, OP_BRANCH, OP_STORE, OP_IMM, OP_REG.
- One sub-module: instruction_field_packer, the combinational format mux plus range check.
- FIFO and address counter stay in the top.

Test Plan:
- R, op 0x33, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> out_word 0x002081B3, out_addr 0x000, one cycle after accept.
- I, op 0x13, rd=1, rs1=0, imm=0xFFFFFFFF -> 0xFFF00093. B, op 0x63, rs1=1, rs2=2, imm=-4 -> 0xFE208EE3.
- U, op 0x37, rd=5, imm=0x12345000 -> 0x123452B7. J, op 0x6F, rd=1, imm=0x800 -> 0x001000EF.
- DEPTH=4, out_ready=0, 5 pushes offered:
  - in_ready drops after the 4th; addresses are 0x0, 0x4, 0x8, 0xC.
  - Then out_ready=1 with continuous push: the 5th word gets 0x10, with no loss or duplication.
- Macro on: I, op 0x13, rd=1, imm=0x800 -> word 0x80000093, out_err=1. B with imm=2 -> out_err=0; B with imm=3 -> out_err=1.
- Mid-stream flush with 3 words buffered -> out_valid=0 next cycle and the next word gets addr BASE_ADDR.
- ADDR_W=4: the 5th push wraps to out_addr 0x0.
- rst_n low mid-burst -> outputs 0 asynchronously.
